// File: rtl/pkg_dist.sv
// Shared types and constants for the pairwise min/max distance engine.
package pkg_dist;

    localparam int unsigned NVAL      = 32;
    localparam int unsigned NBYTES    = 2 * NVAL;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned IDX_W     = 5;

    localparam logic [ADDR_W-1:0] MIN_ADDR = 8'd66;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 8'd68;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        LOAD,
        CMP,
        WR,
        DONE
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } mem_wr_t;

    // |a-b| of two signed words; a 17-bit difference keeps 0x7FFF vs 0x8000 exact.
    function automatic logic [WORD_W-1:0] abs_diff(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W:0] diff;
        diff = {a[WORD_W-1], a} - {b[WORD_W-1], b};
        return diff[WORD_W] ? WORD_W'(-diff) : diff[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read port, synchronous write port.
module data_mem
    import pkg_dist::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [BYTE_W-1:0] rdata_c_o
);

    logic [BYTE_W-1:0] core [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            core[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = core[raddr_i];

endmodule

// File: rtl/dut.sv
// Min/max |a-b| over all unordered pairs of 32 signed 16-bit values held in data memory.
// Loads operands, sweeps pairs j-major, writes both results back, then holds done.
module dut
    import pkg_dist::*;
#(
    parameter int unsigned START_DELAY = 8
) (
    input  logic clk,
    input  logic reset = 1'b0,
    input  logic start,
    output logic done
);

    localparam int unsigned CNT_W = (START_DELAY > NBYTES) ? $clog2(START_DELAY) : $clog2(NBYTES);

    state_e              state_q = IDLE;
    state_e              state_d;
    logic [CNT_W-1:0]    cnt_q   = '0;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    j_q     = '0;
    logic [IDX_W-1:0]    j_d;
    logic [IDX_W-1:0]    k_q     = '0;
    logic [IDX_W-1:0]    k_d;
    logic [WORD_W-1:0]   min_q   = 16'hFFFF;
    logic [WORD_W-1:0]   min_d;
    logic [WORD_W-1:0]   max_q   = 16'h0000;
    logic [WORD_W-1:0]   max_d;
    logic                done_q  = 1'b0;
    logic                done_d;

    logic [WORD_W-1:0]   rf_q [NVAL];
    logic                rf_we_c;
    logic [WORD_W-1:0]   dist_c;
    logic [ADDR_W-1:0]   raddr_c;
    logic [BYTE_W-1:0]   rdata_c;
    mem_wr_t             wr_c;

    data_mem dm (
        .clk       (clk),
        .we_i      (wr_c.we),
        .waddr_i   (wr_c.addr),
        .wdata_i   (wr_c.data),
        .raddr_i   (raddr_c),
        .rdata_c_o (rdata_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            min_q   <= 16'hFFFF;
            max_q   <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            min_q   <= min_d;
            max_q   <= max_d;
            done_q  <= done_d;
        end
    end

    // Even load addresses fill the high byte of an operand, odd ones the low byte.
    always_ff @(posedge clk) begin
        if (rf_we_c) begin
            if (!cnt_q[0]) begin
                rf_q[cnt_q[IDX_W:1]][WORD_W-1:BYTE_W] <= rdata_c;
            end else begin
                rf_q[cnt_q[IDX_W:1]][BYTE_W-1:0] <= rdata_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        min_d   = min_q;
        max_d   = max_q;
        rf_we_c = 1'b0;
        wr_c    = '0;
        raddr_c = ADDR_W'(cnt_q);
        dist_c  = abs_diff(rf_q[j_q], rf_q[k_q]);

        case (state_q)
            IDLE: begin
                if (!start) begin
                    state_d = DELAY;
                    cnt_d   = '0;
                end
            end
            DELAY: begin
                if (start) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(START_DELAY - 1)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                if (start) begin
                    state_d = IDLE;
                end else begin
                    rf_we_c = 1'b1;
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        state_d = CMP;
                        cnt_d   = '0;
                        j_d     = '0;
                        k_d     = IDX_W'(1);
                        min_d   = 16'hFFFF;
                        max_d   = 16'h0000;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CMP: begin
                if (start) begin
                    state_d = IDLE;
                end else begin
                    if (dist_c < min_q) min_d = dist_c;
                    if (dist_c > max_q) max_d = dist_c;
                    if (k_q == IDX_W'(NVAL - 1)) begin
                        if (j_q == IDX_W'(NVAL - 2)) begin
                            state_d = WR;
                            cnt_d   = '0;
                        end else begin
                            j_d = j_q + IDX_W'(1);
                            k_d = j_q + IDX_W'(2);
                        end
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            WR: begin
                if (start) begin
                    state_d = IDLE;
                end else begin
                    wr_c.we = 1'b1;
                    case (cnt_q[1:0])
                        2'd0: begin
                            wr_c.addr = MIN_ADDR;
                            wr_c.data = min_q[WORD_W-1:BYTE_W];
                        end
                        2'd1: begin
                            wr_c.addr = MIN_ADDR + ADDR_W'(1);
                            wr_c.data = min_q[BYTE_W-1:0];
                        end
                        2'd2: begin
                            wr_c.addr = MAX_ADDR;
                            wr_c.data = max_q[WORD_W-1:BYTE_W];
                        end
                        default: begin
                            wr_c.addr = MAX_ADDR + ADDR_W'(1);
                            wr_c.data = max_q[BYTE_W-1:0];
                        end
                    endcase
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (start) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
    end

    assign done = done_q;

endmodule

// File: tb/tb_dut.sv
// Directed self-checking bench for the min/max distance engine.
module tb_dut;
    import pkg_dist::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] vals [NVAL];
    logic [7:0]  snap [MEM_DEPTH];

    dut #(.START_DELAY(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < NVAL; i++) begin
            dut.dm.core[2*i]   = vals[i][15:8];
            dut.dm.core[2*i+1] = vals[i][7:0];
        end
        dut.dm.core[64] = 8'h00;
        dut.dm.core[65] = 8'h00;
        dut.dm.core[66] = 8'hFF;
        dut.dm.core[67] = 8'hFF;
        for (int i = 68; i < MEM_DEPTH; i++) dut.dm.core[i] = 8'h00;
        for (int i = 0; i < MEM_DEPTH; i++) snap[i] = dut.dm.core[i];
    endtask

    // Software reference: brute force over all unordered pairs using integer arithmetic.
    function automatic void model(output logic [15:0] mn, output logic [15:0] mx);
        int a, b, d;
        mn = 16'hFFFF;
        mx = 16'h0000;
        for (int j = 0; j < NVAL; j++) begin
            for (int k = j + 1; k < NVAL; k++) begin
                a = int'($signed(vals[j]));
                b = int'($signed(vals[k]));
                d = a - b;
                if (d < 0) d = -d;
                if (d < int'(mn)) mn = 16'(d);
                if (d > int'(mx)) mx = 16'(d);
            end
        end
    endfunction

    task automatic get_res(output logic [15:0] mn, output logic [15:0] mx);
        mn = {dut.dm.core[66], dut.dm.core[67]};
        mx = {dut.dm.core[68], dut.dm.core[69]};
    endtask

    task automatic run(input bit late, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        if (!late) load_mem();
        start = 1'b0;
        while (cyc < 2000 && !got) begin
            tick();
            cyc++;
            if (late && cyc == 2) load_mem();
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic release_start();
        start = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b expected 0", done);
        end
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        n_checks++;
        if (dut.min_q !== 16'hFFFF || dut.max_q !== 16'h0000) begin
            n_fail++; $display("FAIL reset_minmax: got %h/%h expected ffff/0000", dut.min_q, dut.max_q);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_latency();
        int cyc; bit got; int diffs;
        logic [15:0] mn, mx, emn, emx;
        int init_v [NVAL] = '{100, -200, 3000, 7, -7, 12345, -32000, 500,
                              42, 9999, -1234, 808, 31000, -15000, 256, 77,
                              -99, 1500, 2020, -3030, 4444, 1, -2, 60,
                              700, -800, 9000, -10000, 11, 12000, -13, 14141};
        for (int i = 0; i < NVAL; i++) vals[i] = 16'(init_v[i]);
        run(1'b0, cyc, got);
        n_checks++;
        if (!got || cyc != 573) begin
            n_fail++; $display("FAIL latency: got done=%b after %0d cycles expected 573", got, cyc);
        end
        model(emn, emx);
        get_res(mn, mx);
        n_checks++;
        if (mn !== emn || mx !== emx) begin
            n_fail++; $display("FAIL basic_minmax: got %h/%h expected %h/%h", mn, mx, emn, emx);
        end
        diffs = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if ((i < 66 || i > 69) && dut.dm.core[i] !== snap[i]) diffs++;
        end
        n_checks++;
        if (diffs != 0) begin
            n_fail++; $display("FAIL mem_untouched: got %0d modified bytes expected 0", diffs);
        end
        release_start();
    endtask

    task automatic test_directed();
        int cyc; bit got;
        logic [15:0] mn, mx;
        logic [15:0] exp_mn [4] = '{16'd100, 16'd0, 16'd0, 16'd3};
        logic [15:0] exp_mx [4] = '{16'hFFFF, 16'd217, 16'd0, 16'd93};
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NVAL; i++) begin
                case (t)
                    0:       vals[i] = 16'(i * 100);
                    1:       vals[i] = 16'(i * 7 - 50);
                    2:       vals[i] = 16'hFFFB;
                    default: vals[i] = 16'(i * 3);
                endcase
            end
            if (t == 0) begin
                vals[3] = 16'h7FFF;
                vals[9] = 16'h8000;
            end
            if (t == 1) vals[20] = vals[5];
            run(1'b0, cyc, got);
            get_res(mn, mx);
            n_checks++;
            if (!got || mn !== exp_mn[t] || mx !== exp_mx[t]) begin
                n_fail++;
                $display("FAIL directed_%0d: got done=%b %h/%h expected %h/%h",
                         t, got, mn, mx, exp_mn[t], exp_mx[t]);
            end
            release_start();
        end
    endtask

    task automatic test_handshake();
        int cyc; bit got; int lows;
        for (int i = 0; i < NVAL; i++) vals[i] = 16'(i * i - 100);
        run(1'b0, cyc, got);
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b1) lows++;
        end
        n_checks++;
        if (!got || lows != 0) begin
            n_fail++; $display("FAIL done_hold: got done=%b, %0d low cycles expected 0", got, lows);
        end
        start = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL done_clear: got done=%b state=%0d expected 0/IDLE", done, dut.state_q);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc; bit got;
        logic [15:0] mn, mx, emn, emx;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NVAL; i++) vals[i] = 16'($urandom);
            if (r == 3) vals[7] = vals[30];
            run(1'b1, cyc, got);
            model(emn, emx);
            get_res(mn, mx);
            n_checks++;
            if (!got || mn !== emn || mx !== emx) begin
                n_fail++;
                $display("FAIL b2b_run%0d: got done=%b %h/%h expected %h/%h", r, got, mn, mx, emn, emx);
            end
            start = 1'b1;
            tick();
        end
        tick();
    endtask

    task automatic test_abort();
        int waits; int highs;
        for (int i = 0; i < NVAL; i++) vals[i] = 16'(i * 11);
        load_mem();
        dut.dm.core[66] = 8'hAA;
        dut.dm.core[67] = 8'hBB;
        dut.dm.core[68] = 8'hCC;
        dut.dm.core[69] = 8'hDD;
        start = 1'b0;
        waits = 0;
        while (dut.state_q !== CMP && waits < 200) begin
            tick();
            waits++;
        end
        n_checks++;
        if (dut.state_q !== CMP) begin
            n_fail++; $display("FAIL abort_reach_cmp: got state %0d expected %0d", dut.state_q, CMP);
        end
        repeat (50) tick();
        start = 1'b1;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got state=%0d done=%b expected IDLE/0", dut.state_q, done);
        end
        highs = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done !== 1'b0) highs++;
        end
        n_checks++;
        if (highs != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d done-high cycles expected 0", highs);
        end
        n_checks++;
        if ({dut.dm.core[66], dut.dm.core[67], dut.dm.core[68], dut.dm.core[69]} !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL abort_mem: got %h%h%h%h expected aabbccdd",
                     dut.dm.core[66], dut.dm.core[67], dut.dm.core[68], dut.dm.core[69]);
        end
    endtask

    task automatic test_reset_midrun();
        load_mem();
        start = 1'b0;
        repeat (300) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE || done !== 1'b0 || dut.min_q !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_midrun: got state=%0d done=%b min=%h expected IDLE/0/ffff",
                     dut.state_q, done, dut.min_q);
        end
        start = 1'b1;
        reset = 1'b0;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL reset_release: got state=%0d expected IDLE", dut.state_q);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        test_reset();
        test_basic_latency();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_abort();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
